// File: rtl/dda_interp_multi.sv
// -----------------------------------------------------------------------------
// dda_interp_multi
//
// Multi-axis DDA linear interpolator for step/direction motor drives.
// AXES channels share one dominant step count n and one iteration prescaler.
// Each axis spreads its commanded step count evenly over n iterations. Every
// iteration lasts DIV clocks, and each step pulse is PW clocks wide.
//
// Parameters
//   AXES : number of axis channels
//   W    : magnitude width of n and of each axis field (sign excluded)
//   DIV  : clocks per DDA iteration (>= 2)
//   PW   : pulse high time in clocks (1 .. DIV-1)
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   load-and-go strobe, only sampled while idle
//   abort  in   cancel the running move (no done strobe)
//   n      in   dominant step count (iterations) of the move
//   nx     in   per-axis {sign, magnitude[W-1:0]}; axis a at [a*(W+1) +: W+1]
//   ls     in   per-axis limit switch, active high
//   pulse  out  registered step pulses
//   dir    out  registered direction (sign bits latched at start)
//   busy   out  move in progress
//   done   out  one-cycle strobe at normal completion
//   err    out  sticky: a magnitude exceeded n at the last accepted start
//   fault  out  sticky: limit-switch abort (only with DDA_LS_ABORT_EN)
//
// Configuration macro
//   DDA_LS_ABORT_EN : when defined, a limit switch on any axis with a nonzero
//                     magnitude aborts the move and sets fault. When not
//                     defined, ls only masks that axis's pulses and fault is 0.
// -----------------------------------------------------------------------------
module dda_interp_multi #(
  parameter int AXES = 3,
  parameter int W    = 8,
  parameter int DIV  = 50,
  parameter int PW   = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [W-1:0]          n,
  input  logic [AXES*(W+1)-1:0] nx,
  input  logic [AXES-1:0]       ls,
  output logic [AXES-1:0]       pulse,
  output logic [AXES-1:0]       dir,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  fault
);

  localparam int PSW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(DIV - 1);
  localparam logic [PSW-1:0] PS_PW   = PSW'(PW);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PSW-1:0]  presc_q, presc_d;
  logic [W-1:0]    iter_q,  iter_d;
  logic [W-1:0]    n_q,     n_d;
  logic [W-1:0]    mag_q [AXES];
  logic [W-1:0]    mag_d [AXES];
  logic [W:0]      acc_q [AXES];
  logic [W:0]      acc_d [AXES];
  logic [AXES-1:0] pulse_q, pulse_d;
  logic [AXES-1:0] dir_q,   dir_d;
  logic            done_q,  done_d;
  logic            err_q,   err_d;
  logic            fault_q, fault_d;

  // Per-axis views of the command word and of the accumulator step.
  logic [W-1:0]    mag_in [AXES];
  logic [AXES-1:0] sgn_in;
  logic [AXES-1:0] over;
  logic [W:0]      sum    [AXES];
  logic [AXES-1:0] hit;
  logic            ls_trip;

  for (genvar gi = 0; gi < AXES; gi++) begin : g_axis
    assign mag_in[gi] = nx[gi*(W+1) +: W];
    assign sgn_in[gi] = nx[gi*(W+1) + W];
    assign over[gi]   = (mag_in[gi] > n);
    // acc < n and mag <= n, so the sum always fits in W+1 bits.
    assign sum[gi]    = acc_q[gi] + {1'b0, mag_q[gi]};
    assign hit[gi]    = (sum[gi] >= {1'b0, n_q});
  end

`ifdef DDA_LS_ABORT_EN
  // Only axes that are actually commanded to move can trip the abort.
  logic [AXES-1:0] mag_nz;
  for (genvar gi = 0; gi < AXES; gi++) begin : g_nz
    assign mag_nz[gi] = |mag_q[gi];
  end
  assign ls_trip = |(ls & mag_nz);
`else
  assign ls_trip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    iter_d  = iter_q;
    n_d     = n_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    pulse_d = pulse_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = err_q;
    fault_d = fault_q;

    unique case (state_q)
      S_IDLE: begin
        // abort is meaningless here, so start always takes effect.
        if (start) begin
          dir_d   = sgn_in;
          err_d   = |over;
          fault_d = 1'b0;
          if (n == '0) begin
            done_d = 1'b1;
          end else begin
            n_d = n;
            for (int a = 0; a < AXES; a++) begin
              mag_d[a] = over[a] ? n : mag_in[a];
              // Half-scale preload centres the pulses within the move.
              acc_d[a] = {1'b0, n >> 1};
            end
            presc_d = '0;
            iter_d  = '0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (abort || ls_trip) begin
          state_d = S_IDLE;
          pulse_d = '0;
          fault_d = fault_q | ls_trip;
        end else begin
          presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PSW'(1);

          if (presc_q == '0) begin
            for (int a = 0; a < AXES; a++) begin
              if (hit[a]) begin
                acc_d[a]   = sum[a] - {1'b0, n_q};
                pulse_d[a] = ~ls[a];
              end else begin
                acc_d[a]   = sum[a];
                pulse_d[a] = 1'b0;
              end
            end
            iter_d = iter_q + W'(1);
          end

          if (presc_q == PS_PW) begin
            pulse_d = '0;
          end

          // iter_q reaches n after the last update, so this closes the
          // final iteration on its last prescaler clock.
          if ((presc_q == PS_LAST) && (iter_q == n_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      iter_q  <= '0;
      n_q     <= '0;
      for (int a = 0; a < AXES; a++) begin
        mag_q[a] <= '0;
        acc_q[a] <= '0;
      end
      pulse_q <= '0;
      dir_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      iter_q  <= iter_d;
      n_q     <= n_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      pulse_q <= pulse_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

  assign pulse = pulse_q;
  assign dir   = dir_q;
  assign busy  = (state_q == S_RUN);
  assign done  = done_q;
  assign err   = err_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_dda_interp_multi.sv
// -----------------------------------------------------------------------------
// tb_dda_interp_multi
//
// Scoreboard bench for dda_interp_multi (AXES=3, W=8, DIV=4, PW=2).
// The stimulus process issues moves and pushes the expected end-of-move record.
// The monitor runs on the falling edge. It counts pulses, checks pulse widths,
// and at every end-of-move event (done strobe or busy falling) it pops a
// record and compares it.
// -----------------------------------------------------------------------------
module tb_dda_interp_multi;

  localparam int AXES = 3;
  localparam int W    = 8;
  localparam int DIV  = 4;
  localparam int PW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  abort;
  logic [W-1:0]          n;
  logic [AXES*(W+1)-1:0] nx;
  logic [AXES-1:0]       ls;
  logic [AXES-1:0]       pulse;
  logic [AXES-1:0]       dir;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  fault;

  always #5 clk = ~clk;

  dda_interp_multi #(.AXES(AXES), .W(W), .DIV(DIV), .PW(PW)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .abort(abort),
    .n    (n),
    .nx   (nx),
    .ls   (ls),
    .pulse(pulse),
    .dir  (dir),
    .busy (busy),
    .done (done),
    .err  (err),
    .fault(fault)
  );

  // Number of rising clock edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                    end_cyc;
    bit                    exp_done;
    bit [AXES-1:0]         exp_dir;
    bit                    exp_err;
    bit                    exp_fault;
    logic [AXES-1:0][15:0] exp_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // DDA with half-scale preload: after `iters` iterations an axis has stepped
  // floor((iters*mag + floor(n/2)) / n) times.
  function automatic int ref_pulses(input int nn, input int mg, input int iters);
    return (iters * mg + nn / 2) / nn;
  endfunction

  // ---------------------------------------------------------------- monitor
  bit            prev_busy  = 1'b0;
  bit            prev_rst   = 1'b0;
  bit [AXES-1:0] prev_pulse = '0;
  int            mon_w   [AXES];
  int            mon_cnt [AXES];

  initial begin
    exp_t e;
    for (int a = 0; a < AXES; a++) begin
      mon_w[a]   = 0;
      mon_cnt[a] = 0;
    end
    forever begin
      @(negedge clk);
      for (int a = 0; a < AXES; a++) begin
        if (pulse[a] === 1'b1) begin
          if (!prev_pulse[a]) mon_cnt[a]++;
          mon_w[a]++;
        end else if (prev_pulse[a]) begin
          // A reset may legitimately truncate a pulse.
          if (!prev_rst) chk($sformatf("pulse_width_axis%0d", a), mon_w[a], PW);
          mon_w[a] = 0;
        end
      end
      if ((done === 1'b1) || (prev_busy && (busy === 1'b0))) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_move_end", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("end_cycle", cyc, e.end_cyc);
          chk("done",      int'(done),  int'(e.exp_done));
          chk("busy_end",  int'(busy),  0);
          chk("pulse_end", int'(pulse), 0);
          chk("dir",       int'(dir),   int'(e.exp_dir));
          chk("err",       int'(err),   int'(e.exp_err));
          chk("fault",     int'(fault), int'(e.exp_fault));
          for (int a = 0; a < AXES; a++)
            chk($sformatf("pulse_count_axis%0d", a), mon_cnt[a], int'(e.exp_cnt[a]));
          $display("txn end cycle %0d done=%0d counts=%0d/%0d/%0d dir=%b err=%0d fault=%0d",
                   cyc, done, mon_cnt[0], mon_cnt[1], mon_cnt[2], dir, err, fault);
        end
        for (int a = 0; a < AXES; a++) mon_cnt[a] = 0;
      end
      prev_busy  = (busy === 1'b1);
      prev_pulse = pulse;
      prev_rst   = (rst === 1'b1);
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  // mode: 0 run to completion, 1 abort at iteration k, 2 reset mid-pulse of
  // iteration k, 3 re-pulse start mid-move (must be ignored).
  task automatic run_move(input int nn, input int mg0, input int mg1, input int mg2,
                          input bit [AXES-1:0] sg, input bit [AXES-1:0] lsv,
                          input int mode, input int k);
    int   mg [AXES];
    int   cm [AXES];
    int   iters;
    int   m;
    bit   trip;
    exp_t e;
    mg[0] = mg0;
    mg[1] = mg1;
    mg[2] = mg2;
    e.exp_err   = 1'b0;
    e.exp_dir   = sg;
    e.exp_fault = 1'b0;
    e.exp_done  = 1'b1;
    e.exp_cnt   = '0;
    for (int a = 0; a < AXES; a++) begin
      cm[a] = (mg[a] > nn) ? nn : mg[a];
      if (mg[a] > nn) e.exp_err = 1'b1;
    end
    trip = 1'b0;
`ifdef DDA_LS_ABORT_EN
    for (int a = 0; a < AXES; a++)
      if (lsv[a] && (cm[a] != 0) && (nn != 0)) trip = 1'b1;
`endif
    n = W'(nn);
    for (int a = 0; a < AXES; a++) nx[a*(W+1) +: (W+1)] = {sg[a], W'(mg[a])};
    ls    = lsv;
    start = 1'b1;
    m     = cyc;
    tick();
    start = 1'b0;

    iters = nn;
    if (nn == 0) begin
      e.end_cyc = m + 1;
      iters = 0;
    end else if (trip) begin
      e.end_cyc   = m + 2;
      e.exp_done  = 1'b0;
      e.exp_fault = 1'b1;
      iters = 0;
    end else if (mode == 1) begin
      e.end_cyc  = m + 2 + k * DIV;
      e.exp_done = 1'b0;
      iters = k;
    end else if (mode == 2) begin
      e.end_cyc  = m + 3 + k * DIV;
      e.exp_done = 1'b0;
      e.exp_dir  = '0;
      e.exp_err  = 1'b0;
      iters = k + 1;
    end else begin
      e.end_cyc = m + 1 + nn * DIV;
    end
    if (nn != 0)
      for (int a = 0; a < AXES; a++)
        e.exp_cnt[a] = lsv[a] ? 16'd0 : 16'(ref_pulses(nn, cm[a], iters));
    sb_q.push_back(e);

    if (nn != 0 && !trip) begin
      if (mode == 1) begin
        wait_cyc(m + 1 + k * DIV);
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end else if (mode == 2) begin
        wait_cyc(m + 2 + k * DIV);
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else if (mode == 3 && nn >= 3) begin
        wait_cyc(m + 1 + 2 * DIV);
        n  = W'($urandom_range(1, 12));
        nx = AXES*(W+1)'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    wait_cyc(e.end_cyc + 2);
    ls = '0;
  endtask

  initial begin
    int nn, mode, k;
    int mr [AXES];
    bit [AXES-1:0] lsr;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    n     = '0;
    nx    = '0;
    ls    = '0;
    tick();
    tick();
    chk("reset_pulse", int'(pulse), 0);
    chk("reset_dir",   int'(dir),   0);
    chk("reset_busy",  int'(busy),  0);
    chk("reset_done",  int'(done),  0);
    chk("reset_err",   int'(err),   0);
    chk("reset_fault", int'(fault), 0);
    rst = 1'b0;
    tick();

    // Directed cases.
    run_move(10, 10, 5, 0, 3'b001, 3'b000, 0, 0);  // basic 10/5/0
    run_move(0,  3,  0, 0, 3'b010, 3'b000, 0, 0);  // n=0: immediate done
    run_move(10, 12, 4, 7, 3'b000, 3'b000, 0, 0);  // clamp + err
    run_move(10, 3,  6, 9, 3'b000, 3'b010, 0, 0);  // ls[1] held high
    run_move(8,  8,  3, 5, 3'b100, 3'b000, 3, 0);  // start mid-move ignored
    run_move(10, 10, 7, 2, 3'b000, 3'b000, 1, 3);  // abort at iteration 3
    run_move(6,  6,  4, 1, 3'b011, 3'b000, 2, 2);  // reset mid-pulse
    run_move(4,  2,  0, 0, 3'b000, 3'b000, 0, 0);  // after reset: 2 pulses
    run_move(1,  1,  1, 0, 3'b111, 3'b000, 0, 0);  // single iteration

    // Randomized moves.
    for (int t = 0; t < 14; t++) begin
      nn = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      for (int a = 0; a < AXES; a++) begin
        mr[a]  = $urandom_range(0, nn + 2);
        lsr[a] = ($urandom_range(0, 4) == 0);
      end
      mode = $urandom_range(0, 3);
      k    = (nn >= 2) ? $urandom_range(1, nn - 1) : 0;
      if ((mode == 1 || mode == 2) && nn < 2) mode = 0;
      run_move(nn, mr[0], mr[1], mr[2], AXES'($urandom), lsr, mode, k);
    end

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
    chk("scoreboard_drained", sb_q.size(), 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
